serial_adder: RTL and testbench

- Parametrised, multi-cycle successor to the combinational one-bit full adder.
- Adds (or subtracts) two WIDTH-bit operands DIGIT bits per clock.
- Uses one DIGIT-bit full-adder slice and a registered carry.
- Provides a start/busy/done handshake, carry-out and signed-overflow flags. Used where area matters more than latency.

---
 rtl/serial_adder.sv | 130 +++++++++++++
 tb/tb_serial_adder.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// serial_adder: digit-serial adder/subtractor.
// Processes two WIDTH-bit operands DIGIT bits per clock through one
// DIGIT-bit adder slice and a registered carry. Each operation takes N = WIDTH/DIGIT cycles.
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-high reset; also aborts an operation in flight
//   start       request an operation; sampled only when busy=0 (IDLE or DONE)
//   a, b        operands, captured on the accepting edge
//   cin         carry-in for add mode; ignored when sub=1
//   sub         0: a+b+cin, 1: a-b (a+~b+1)
//   busy        high during the N compute cycles
//   done        one-cycle pulse when s/cout/ovf are updated
//   s           result modulo 2^WIDTH
//   cout        carry out of the MSB (no-borrow flag in sub mode)
//   ovf         two's-complement overflow

// One DIGIT-bit full-adder slice. cm is the carry into the slice's top bit,
// recovered from that bit's sum and its two input bits.
module serial_adder_slice #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co,
  output logic             cm
);
  assign {co, s} = {1'b0, a} + {1'b0, b} + {{DIGIT{1'b0}}, ci};
  assign cm      = s[DIGIT-1] ^ a[DIGIT-1] ^ b[DIGIT-1];
endmodule

module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] K_LAST = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q, b_q;   // b_q already holds ~b in sub mode
  logic [WIDTH-1:0] res_q, res_nx;
  logic             c_q;
  logic [CW-1:0]    k;

  logic [DIGIT-1:0] sum_d;
  logic             co_d, cm_d;

  serial_adder_slice #(.DIGIT(DIGIT)) u_slice (
    .a  (a_q[k*DIGIT +: DIGIT]),
    .b  (b_q[k*DIGIT +: DIGIT]),
    .ci (c_q),
    .s  (sum_d),
    .co (co_d),
    .cm (cm_d)
  );

  // Internal result with the current digit merged in; on the last digit this
  // is the complete result, so s can be loaded in the same edge.
  always_comb begin
    res_nx = res_q;
    res_nx[k*DIGIT +: DIGIT] = sum_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      s     <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
      res_q <= '0;
      c_q   <= 1'b0;
      k     <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            // The mode is folded into the operand and the initial carry,
            // so the datapath is the same adder in both modes.
            a_q   <= a;
            b_q   <= sub ? ~b : b;
            c_q   <= sub | cin;
            k     <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          res_q <= res_nx;
          c_q   <= co_d;
          if (k == K_LAST) begin
            s     <= res_nx;
            cout  <= co_d;
            ovf   <= cm_d ^ co_d;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            k <= k + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder. Four instances cover
// (WIDTH,DIGIT) = (8,1), (8,4), (8,8) and (4,1).
module tb_serial_adder;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_v[4], start_v[4], cin_v[4], sub_v[4];
  logic       busy_v[4], done_v[4], cout_v[4], ovf_v[4];
  logic [7:0] a_v[3], b_v[3];
  logic [3:0] a3, b3;
  logic [7:0] s0, s1, s2;
  logic [3:0] s3;

  int checks = 0;
  int errors = 0;

  serial_adder #(.WIDTH(8), .DIGIT(1)) u0 (
    .clk(clk), .rst(rst_v[0]), .start(start_v[0]), .a(a_v[0]), .b(b_v[0]),
    .cin(cin_v[0]), .sub(sub_v[0]), .busy(busy_v[0]), .done(done_v[0]),
    .s(s0), .cout(cout_v[0]), .ovf(ovf_v[0]));
  serial_adder #(.WIDTH(8), .DIGIT(4)) u1 (
    .clk(clk), .rst(rst_v[1]), .start(start_v[1]), .a(a_v[1]), .b(b_v[1]),
    .cin(cin_v[1]), .sub(sub_v[1]), .busy(busy_v[1]), .done(done_v[1]),
    .s(s1), .cout(cout_v[1]), .ovf(ovf_v[1]));
  serial_adder #(.WIDTH(8), .DIGIT(8)) u2 (
    .clk(clk), .rst(rst_v[2]), .start(start_v[2]), .a(a_v[2]), .b(b_v[2]),
    .cin(cin_v[2]), .sub(sub_v[2]), .busy(busy_v[2]), .done(done_v[2]),
    .s(s2), .cout(cout_v[2]), .ovf(ovf_v[2]));
  serial_adder #(.WIDTH(4), .DIGIT(1)) u3 (
    .clk(clk), .rst(rst_v[3]), .start(start_v[3]), .a(a3), .b(b3),
    .cin(cin_v[3]), .sub(sub_v[3]), .busy(busy_v[3]), .done(done_v[3]),
    .s(s3), .cout(cout_v[3]), .ovf(ovf_v[3]));

  function automatic int wid(input int u);
    return (u == 3) ? 4 : 8;
  endfunction

  function automatic int ncyc(input int u);
    case (u)
      0: return 8;
      1: return 2;
      2: return 1;
      default: return 4;
    endcase
  endfunction

  function automatic logic [7:0] get_s(input int u);
    case (u)
      0: return s0;
      1: return s1;
      2: return s2;
      default: return {4'b0, s3};
    endcase
  endfunction

  // Reference: plain integer arithmetic; overflow = signed result out of range.
  function automatic void ref_model(input int w, input int a, input int b,
                                    input int cin, input int sub,
                                    output int rs, output int rc, output int ro);
    int m, h, sa, sb, r;
    m = (1 << w) - 1;
    h = 1 << (w - 1);
    a = a & m;
    b = b & m;
    cin = cin & 1;
    sa = (a >= h) ? a - (1 << w) : a;
    sb = (b >= h) ? b - (1 << w) : b;
    if (sub != 0) begin
      rs = (a - b) & m;
      rc = (a >= b) ? 1 : 0;
      r  = sa - sb;
    end else begin
      rs = (a + b + cin) & m;
      rc = ((a + b + cin) > m) ? 1 : 0;
      r  = sa + sb + cin;
    end
    ro = (r < -h || r > h - 1) ? 1 : 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input int u, input int a, input int b, input int cin, input int sub);
    logic [31:0] av, bv;
    av = a;
    bv = b;
    if (u == 3) begin
      a3 = av[3:0];
      b3 = bv[3:0];
    end else begin
      a_v[u] = av[7:0];
      b_v[u] = bv[7:0];
    end
    cin_v[u] = (cin & 1) != 0;
    sub_v[u] = (sub & 1) != 0;
  endtask

  // Launch one operation, scramble inputs while busy (optionally pulsing start),
  // then check latency, busy length, result holding and the result.
  task automatic do_op(input int u, input int a, input int b, input int cin,
                       input int sub, input bit glitch);
    int es, ec, eo, lat, bc;
    logic [7:0] prev;
    logic held;
    ref_model(wid(u), a, b, cin, sub, es, ec, eo);
    prev = get_s(u);
    set_in(u, a, b, cin, sub);
    start_v[u] = 1'b1;
    tick();
    start_v[u] = 1'b0;
    set_in(u, int'($urandom), int'($urandom), int'($urandom_range(0, 1)),
           int'($urandom_range(0, 1)));
    lat = 0;
    bc = 0;
    held = 1'b1;
    while (done_v[u] !== 1'b1 && lat < 40) begin
      if (busy_v[u] === 1'b1) begin
        bc++;
        if (get_s(u) !== prev) held = 1'b0;
      end
      start_v[u] = glitch && (lat == 1);
      tick();
      lat++;
    end
    start_v[u] = 1'b0;
    chk($sformatf("u%0d_latency", u), lat, ncyc(u));
    chk($sformatf("u%0d_busy_cycles", u), bc, ncyc(u));
    chk($sformatf("u%0d_s_held", u), {31'b0, held}, 1);
    chk($sformatf("u%0d_s a=%0h b=%0h c=%0d sub=%0d", u, a, b, cin, sub), get_s(u), es);
    chk($sformatf("u%0d_cout", u), cout_v[u], ec);
    chk($sformatf("u%0d_ovf", u), ovf_v[u], eo);
  endtask

  task automatic idle(input int u);
    tick();
    chk($sformatf("u%0d_done_pulse_end", u), done_v[u], 0);
    chk($sformatf("u%0d_idle_busy", u), busy_v[u], 0);
  endtask

  initial begin
    int dcnt;
    for (int u = 0; u < 4; u++) begin
      rst_v[u] = 1'b1;
      start_v[u] = 1'b0;
      set_in(u, 0, 0, 0, 0);
    end
    tick();
    start_v[0] = 1'b1;          // start on a reset edge must be ignored
    tick();
    start_v[0] = 1'b0;
    for (int u = 0; u < 4; u++) begin
      chk($sformatf("u%0d_rst_busy", u), busy_v[u], 0);
      chk($sformatf("u%0d_rst_done", u), done_v[u], 0);
      chk($sformatf("u%0d_rst_s", u), get_s(u), 0);
      chk($sformatf("u%0d_rst_cout", u), cout_v[u], 0);
      chk($sformatf("u%0d_rst_ovf", u), ovf_v[u], 0);
      rst_v[u] = 1'b0;
    end

    // Directed cases with literal expectations.
    do_op(0, 'h5A, 'h3C, 0, 0, 0);
    chk("plan_add_s", s0, 'h96); chk("plan_add_cout", cout_v[0], 0); chk("plan_add_ovf", ovf_v[0], 1);
    idle(0);
    do_op(0, 'hFF, 'h01, 0, 0, 0);
    chk("plan_wrap_s", s0, 'h00); chk("plan_wrap_cout", cout_v[0], 1); chk("plan_wrap_ovf", ovf_v[0], 0);
    idle(0);
    do_op(0, 'hFF, 'h00, 1, 0, 0);
    chk("plan_cin_s", s0, 'h00); chk("plan_cin_cout", cout_v[0], 1);
    idle(0);
    do_op(0, 'h10, 'h20, 1, 1, 0);
    chk("plan_sub1_s", s0, 'hF0); chk("plan_sub1_cout", cout_v[0], 0); chk("plan_sub1_ovf", ovf_v[0], 0);
    idle(0);
    do_op(0, 'h80, 'h01, 1, 1, 0);
    chk("plan_sub2_s", s0, 'h7F); chk("plan_sub2_cout", cout_v[0], 1); chk("plan_sub2_ovf", ovf_v[0], 1);
    idle(0);

    // start while busy, then back-to-back start in the DONE cycle
    do_op(0, int'($urandom), int'($urandom), int'($urandom_range(0, 1)), 0, 1);
    do_op(0, int'($urandom), int'($urandom), 0, 1, 1);
    do_op(0, 'h12, 'h34, 0, 0, 0);
    idle(0);

    // Abort mid-operation
    set_in(0, 'h77, 'h11, 0, 0);
    start_v[0] = 1'b1;
    tick();
    start_v[0] = 1'b0;
    tick();
    tick();
    rst_v[0] = 1'b1;
    tick();
    rst_v[0] = 1'b0;
    chk("abort_busy", busy_v[0], 0);
    chk("abort_done", done_v[0], 0);
    chk("abort_s", s0, 0);
    chk("abort_cout", cout_v[0], 0);
    chk("abort_ovf", ovf_v[0], 0);
    dcnt = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done_v[0] !== 1'b0) dcnt++;
    end
    chk("abort_no_done", dcnt, 0);
    do_op(0, 'hC3, 'h5A, 1, 0, 0);
    idle(0);

    // Random operations on the 8-bit instances
    for (int u = 0; u < 3; u++) begin
      for (int i = 0; i < 25; i++) begin
        do_op(u, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
              int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
              (u == 0) && ($urandom_range(0, 3) == 0));
        if ($urandom_range(0, 1) == 1) idle(u);
      end
      idle(u);
    end

    // Exhaustive 4-bit sweep
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int c = 0; c < 2; c++)
          for (int m = 0; m < 2; m++)
            do_op(3, a, b, c, m, 0);
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
